// File: rtl/mul_arb_pkg.sv
// Shared state type, sizing constants and the round-robin pick helper for mul_share_arbiter.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_REQ_MAX = 8;
    localparam int PTR_W     = $clog2(N_REQ_MAX);

    // Unused high valid bits must be zero, so rotating over all 8 slots gives modulo-N order.
    function automatic logic [N_REQ_MAX-1:0] rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                                      input logic [PTR_W-1:0]     ptr);
        logic [N_REQ_MAX-1:0] grant;
        logic [PTR_W-1:0]     idx;
        grant = '0;
        for (int k = N_REQ_MAX; k >= 1; k--) begin
            idx = ptr + PTR_W'(k);
            if (valid[idx]) grant = N_REQ_MAX'(1) << idx;
        end
        return grant;
    endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational multiplier: float (ARITH_TYPE=0, truncating, zero-exponent inputs give zero,
// no inf/NaN handling) or signed fixed point Q(INTEGER.FRACTION) (ARITH_TYPE=1, wrapping).
module multiplier #(
    parameter int ARITH_TYPE = 0,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int INTEGER    = 12,
    parameter int FRACTION   = 20
)(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    generate
        if (ARITH_TYPE == 1) begin : g_fixed
            logic signed [2*DATA_WIDTH-1:0] full;
            logic                           unused_fixed;

            assign full   = (2*DATA_WIDTH)'($signed(a)) * (2*DATA_WIDTH)'($signed(b));
            assign result = DATA_WIDTH'(full[FRACTION +: INTEGER+FRACTION]);
            assign unused_fixed = ^{full[2*DATA_WIDTH-1:INTEGER+2*FRACTION], full[FRACTION-1:0],
                                    ((1 + E + M) != DATA_WIDTH)};
        end else begin : g_float
            localparam int BIAS = (1 << (E-1)) - 1;
            logic           sign;
            logic [E-1:0]   ea, eb;
            logic [M:0]     ma, mb;
            logic [2*M+1:0] prod;
            logic [E+1:0]   exp_sum;
            logic [M-1:0]   mant;
            logic           zero;
            logic           unused_float;

            assign sign    = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
            assign ea      = a[M +: E];
            assign eb      = b[M +: E];
            assign ma      = {1'b1, a[M-1:0]};
            assign mb      = {1'b1, b[M-1:0]};
            assign prod    = (2*M+2)'(ma) * (2*M+2)'(mb);
            // Significand product lies in [1,4); the top bit selects the one-place renormalisation.
            assign mant    = prod[2*M+1] ? prod[2*M -: M] : prod[2*M-1 -: M];
            assign exp_sum = (E+2)'(ea) + (E+2)'(eb) + (E+2)'(prod[2*M+1]) - (E+2)'(BIAS);
            assign zero    = (ea == '0) || (eb == '0);
            assign result  = zero ? '0 : DATA_WIDTH'({sign, exp_sum[E-1:0], mant});
            assign unused_float = ^{exp_sum[E+1:E], prod[M-1:0], ((INTEGER + FRACTION) != DATA_WIDTH)};
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// One-hot request arbiter. Round-robin from ptr+1 by default; with MUL_ARB_FIXED_PRIO_EN defined
// the lowest index always wins and the ptr input does not exist.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
)(
    input  logic [N-1:0]    valid,
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
    input  logic [ID_W-1:0] ptr,
`endif
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [N_REQ_MAX-1:0] pick;

`ifdef MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (valid[k]) pick = N_REQ_MAX'(1) << k;
        end
    end
`else
    always_comb pick = rr_pick(N_REQ_MAX'(valid), PTR_W'(ptr));
`endif

    always_comb begin
        grant_id = '0;
        for (int k = 0; k < N_REQ_MAX; k++) begin
            if (pick[k]) grant_id = ID_W'(k);
        end
    end

    assign grant = pick[N-1:0];

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier among N_REQ requesters with valid/ready handshakes and ID-tagged results.
// Build option: MUL_ARB_FIXED_PRIO_EN replaces round-robin with lowest-index-first priority.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int ARITH_TYPE = 0,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int INTEGER    = 12,
    parameter int FRACTION   = 20,
    parameter int N_REQ      = 4
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic [$clog2(N_REQ)-1:0]    resp_id
);

    localparam int ID_W = $clog2(N_REQ);

    state_t                state_q, state_d;
    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_id;
    logic                  arb_en;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] a_p0, b_p0, prod;
    logic [ID_W-1:0]       id_p0;

`ifdef MUL_ARB_FIXED_PRIO_EN
    rr_arbiter #(.N(N_REQ)) u_arb (
        .valid    (req_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );
`else
    logic [ID_W-1:0] rr_ptr;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_ptr <= ID_W'(N_REQ-1);
        else if (xfer) rr_ptr <= grant_id;
    end
`endif

    // A finished result frees the multiplier in the same cycle it is consumed, allowing back-to-back grants.
    always_comb begin
        arb_en    = rst_n && ((state_q == IDLE) || ((state_q == DONE) && resp_ready));
        req_ready = arb_en ? grant : '0;
        xfer      = |req_ready;
        state_d   = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = CALC;
            CALC:    state_d = DONE;
            DONE:    if (resp_ready) state_d = xfer ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Stage p0: operands of the granted requester isolate the multiplier input cone
    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p0  <= req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            b_p0  <= req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            id_p0 <= grant_id;
        end
    end

    multiplier #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (DATA_WIDTH),
        .E          (E),
        .M          (M),
        .INTEGER    (INTEGER),
        .FRACTION   (FRACTION)
    ) u_mul (
        .a      (a_p0),
        .b      (b_p0),
        .result (prod)
    );

    // Stage p1: registered product and tag, held until the consumer accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else if (state_q == CALC) begin
            resp_valid <= 1'b1;
            resp_data  <= prod;
            resp_id    <= id_p0;
        end else if ((state_q == DONE) && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: a float and a fixed-point instance share stimulus and are
// compared each cycle against a transaction-level model of arbitration and arithmetic.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int FRAC = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_a, req_b;
    logic          resp_ready;
    logic [N-1:0]  rdy_flt, rdy_fix;
    logic          rv_flt, rv_fix;
    logic [DW-1:0] data_flt, data_fix;
    logic [1:0]    id_flt, id_fix;

    always #5 clk = ~clk;

    mul_share_arbiter #(.ARITH_TYPE(0), .DATA_WIDTH(DW), .E(8), .M(23), .INTEGER(12),
                        .FRACTION(FRAC), .N_REQ(N)) dut_flt (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_flt),
        .req_a(req_a), .req_b(req_b), .resp_valid(rv_flt), .resp_ready(resp_ready),
        .resp_data(data_flt), .resp_id(id_flt)
    );

    mul_share_arbiter #(.ARITH_TYPE(1), .DATA_WIDTH(DW), .E(8), .M(23), .INTEGER(12),
                        .FRACTION(FRAC), .N_REQ(N)) dut_fix (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_fix),
        .req_a(req_a), .req_b(req_b), .resp_valid(rv_fix), .resp_ready(resp_ready),
        .resp_data(data_fix), .resp_id(id_fix)
    );

    // requesters
    logic [DW-1:0] op_a [N];
    logic [DW-1:0] op_b [N];
    logic [N-1:0]  req_v, hold;
    bit            rand_req, rand_rdy;

    assign req_valid = req_v;
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = op_a[i];
            req_b[i*DW +: DW] = op_b[i];
        end
    end

    // reference model
    bit            m_calc, m_rv;
    int            m_calc_id, m_id, m_last;
    logic [DW-1:0] m_calc_flt, m_calc_fix, m_flt, m_fix;
    int            cyc;

    // samples of the last stepped cycle
    logic [N-1:0]  s_rdy;
    logic          s_rv, s_resp_ready;
    logic [DW-1:0] s_flt, s_fix;
    logic [1:0]    s_id;
    int            s_cyc;
    int            ids[$];
    int            hs_cyc[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic real f32_to_real(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        r = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** e);
        return x[31] ? -r : r;
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fix_mul(input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p >>> FRAC;
        return q[31:0];
    endfunction

    function automatic logic [31:0] rand_float();
        int k;
        real r;
        k = int'($urandom_range(1, 255));
        r = real'(k) / 16.0;
        if ($urandom_range(0, 1) == 1) r = -r;
        return real_to_f32(r);
    endfunction

    task automatic new_ops(input int i);
        op_a[i] = rand_float();
        op_b[i] = rand_float();
    endtask

    function automatic logic [N-1:0] exp_grant();
        int i;
        if (m_calc || (m_rv && !resp_ready)) return '0;
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (req_v[k]) return N'(1) << k;
`else
        for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (req_v[i]) return N'(1) << i;
        end
`endif
        return '0;
    endfunction

    task automatic step();
        logic [N-1:0] eg;
        int gi;
        #1;
        eg = exp_grant();
        s_rdy = rdy_flt; s_rv = rv_flt; s_flt = data_flt; s_fix = data_fix;
        s_id = id_flt; s_resp_ready = resp_ready; s_cyc = cyc;
        check("req_ready_flt", rdy_flt, eg);
        check("req_ready_fix", rdy_fix, eg);
        check("resp_valid_flt", rv_flt, m_rv);
        check("resp_valid_fix", rv_fix, m_rv);
        if (m_rv) begin
            check("resp_data_flt", data_flt, m_flt);
            check("resp_data_fix", data_fix, m_fix);
            check("resp_id_flt", id_flt, m_id);
            check("resp_id_fix", id_fix, m_id);
        end
        if (rv_flt && resp_ready) begin
            ids.push_back(int'(id_flt));
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (m_rv && s_resp_ready) m_rv = 1'b0;
        if (m_calc) begin
            m_rv = 1'b1; m_id = m_calc_id; m_flt = m_calc_flt; m_fix = m_calc_fix;
        end
        m_calc = 1'b0;
        gi = -1;
        for (int i = 0; i < N; i++) if (eg[i]) gi = i;
        if (gi >= 0) begin
            m_calc     = 1'b1;
            m_calc_id  = gi;
            m_calc_flt = real_to_f32(f32_to_real(op_a[gi]) * f32_to_real(op_b[gi]));
            m_calc_fix = fix_mul(op_a[gi], op_b[gi]);
            m_last     = gi;
            if (hold[gi]) new_ops(gi);
            else          req_v[gi] = 1'b0;
        end
        if (rand_req) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                    new_ops(i);
                end
            end
        end
        if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_resp_valid", rv_flt, 1'b0);
        check("rst_resp_data_flt", data_flt, 32'h0);
        check("rst_resp_data_fix", data_fix, 32'h0);
        check("rst_resp_id", id_flt, 2'd0);
        check("rst_req_ready", rdy_flt, 4'h0);
        m_calc = 1'b0; m_rv = 1'b0; m_last = N - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_cyc, r_cyc;
        int exp_id;
        int n3;
        logic [DW-1:0] r_flt, r_fix, cap_flt;
        logic [1:0] r_id, cap_id;

        req_v = '0; hold = '0; resp_ready = 1'b0; rand_req = 0; rand_rdy = 0; cyc = 0;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
        m_calc = 0; m_rv = 0; m_last = N - 1; m_id = 0;
        m_flt = '0; m_fix = '0; m_calc_flt = '0; m_calc_fix = '0; m_calc_id = 0;
        @(negedge clk);
        do_reset();

        // idle, resp_ready high with nothing pending
        resp_ready = 1'b1;
        repeat (3) step();

        // float 2.0 * 3.0 from requester 0
        op_a[0] = 32'h40000000; op_b[0] = 32'h40400000; req_v[0] = 1'b1;
        g_cyc = -100; r_cyc = -1; r_flt = '0; r_id = '1;
        for (int t = 0; t < 10 && r_cyc < 0; t++) begin
            step();
            if (s_rdy != '0 && g_cyc < 0) g_cyc = s_cyc;
            if (s_rv) begin r_cyc = s_cyc; r_flt = s_flt; r_id = s_id; end
        end
        check("flt_latency", r_cyc - g_cyc, 2);
        check("flt_data", r_flt, 32'h40C00000);
        check("flt_id", r_id, 2'd0);
        repeat (2) step();

        // fixed 1.5 * 2.0 from requester 2
        op_a[2] = 32'h00180000; op_b[2] = 32'h00200000; req_v[2] = 1'b1;
        r_cyc = -1; r_fix = '0; r_id = '1;
        for (int t = 0; t < 10 && r_cyc < 0; t++) begin
            step();
            if (s_rv) begin r_cyc = s_cyc; r_fix = s_fix; r_id = s_id; end
        end
        check("fix_data", r_fix, 32'h00300000);
        check("fix_id", r_id, 2'd2);

        // all requesters continuously valid
        do_reset();
        hold = '1; req_v = '1;
        for (int i = 0; i < N; i++) new_ops(i);
        resp_ready = 1'b1;
        ids.delete(); hs_cyc.delete();
        repeat (16) step();
        check("rot_count_ok", ids.size() >= 6, 1'b1);
        for (int k = 0; k < 6 && k < ids.size(); k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = k % 4;
`endif
            check("rot_id", ids[k], exp_id);
        end
        for (int k = 0; k < 5 && k + 1 < hs_cyc.size(); k++)
            check("rot_interval", hs_cyc[k+1] - hs_cyc[k], 2);

        // consumer stall for 5 cycles in DONE
        for (int t = 0; t < 10 && !m_calc; t++) step();
        resp_ready = 1'b0;
        step();
        step();
        cap_flt = s_flt; cap_id = s_id;
        check("stall_valid", s_rv, 1'b1);
        check("stall_ready", s_rdy, 4'h0);
        repeat (4) begin
            step();
            check("stall_data", s_flt, cap_flt);
            check("stall_id", s_id, cap_id);
            check("stall_ready", s_rdy, 4'h0);
        end
        resp_ready = 1'b1;
        step();
        check("release_grant", s_rdy != '0, 1'b1);

        // reset while in CALC
        for (int t = 0; t < 10 && !m_calc; t++) step();
        do_reset();
        ids.delete();
        step();
        check("post_rst_grant", s_rdy, 4'b0001);
        repeat (4) step();
        check("post_rst_first_id", ids.size() > 0 ? ids[0] : -1, 0);

        // requesters 1 and 3 only
        do_reset();
        hold = 4'b1010; req_v = 4'b1010;
        new_ops(1); new_ops(3);
        ids.delete();
        repeat (16) step();
        n3 = 0;
        for (int k = 0; k < ids.size(); k++) if (ids[k] == 3) n3++;
        for (int k = 0; k < 6 && k < ids.size(); k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            exp_id = 1;
`else
            exp_id = (k % 2 == 0) ? 1 : 3;
`endif
            check("pair_id", ids[k], exp_id);
        end
`ifdef MUL_ARB_FIXED_PRIO_EN
        check("pair_req3_never", n3, 0);
`else
        check("pair_req3_served", n3 > 0, 1'b1);
`endif

        // randomised traffic and back-pressure
        do_reset();
        hold = '0; req_v = '0;
        rand_req = 1; rand_rdy = 1;
        repeat (1500) step();
        rand_req = 0; rand_rdy = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
